// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one data memory between the data-memory stage (port D) and
//   instruction fetch (port I). At most one request is forwarded per cycle.
//   Accepted reads are tracked in a tag pipeline so that returning data is
//   steered to the port that asked for it. A wait counter bounds how long
//   fetch can lose to the data stage.
//
// Parameters
//   RD_LAT   : cycles from accepted read to mem_rdata valid (1..4)
//   MAX_WAIT : consecutive lost cycles before port I takes priority (1..15)
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   d_rd_i/d_wr_i/d_dump_i         port D strobes
//   d_addr_i/d_wdata_i             port D address / write data
//   d_stall_o/d_acc_o              port D handshake
//   d_rvalid_o/d_rdata_o           port D read return
//   i_rd_i/i_addr_i                port I fetch request
//   i_stall_o/i_acc_o              port I handshake
//   i_rvalid_o/i_rdata_o           port I read return
//   mem_*_o                        request to the memory macro
//   mem_stall_i/mem_rdata_i        memory back-pressure / read data
//   err_o                          D asserted read and write together
module mem_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  input  logic        d_dump_i,
  output logic        d_stall_o,
  output logic        d_acc_o,
  output logic        d_rvalid_o,
  output logic [15:0] d_rdata_o,
  input  logic        i_rd_i,
  input  logic [15:0] i_addr_i,
  output logic        i_stall_o,
  output logic        i_acc_o,
  output logic        i_rvalid_o,
  output logic [15:0] i_rdata_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        mem_dump_o,
  input  logic        mem_stall_i,
  input  logic [15:0] mem_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] vld_q;   // tag pipeline: read in flight
  logic [RD_LAT-1:0] src_q;   // tag pipeline: 1 = port I, 0 = port D

  logic d_req, d_rd_eff, d_win, i_win, d_acc, i_acc, rd_acc;

  // A simultaneous read+write from D is flagged and handled as a write only.
  assign d_rd_eff = d_rd_i & ~d_wr_i;
  assign d_req    = d_rd_i | d_wr_i;

  // D has priority unless fetch has been starved for MAX_WAIT cycles.
  assign i_win  = ~rst_i & i_rd_i & (~d_req | (starve_q == MAX_CNT));
  assign d_win  = ~rst_i & d_req & ~i_win;
  assign d_acc  = d_win & ~mem_stall_i;
  assign i_acc  = i_win & ~mem_stall_i;
  assign rd_acc = (d_acc & d_rd_eff) | i_acc;

  assign d_acc_o   = d_acc;
  assign i_acc_o   = i_acc;
  assign d_stall_o = d_req & ~d_acc;
  assign i_stall_o = i_rd_i & ~i_acc;
  assign err_o     = ~rst_i & d_rd_i & d_wr_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_dump_o  = 1'b0;
    if (d_win) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_rd_o    = d_rd_eff;
      mem_wr_o    = d_wr_i;
      mem_dump_o  = d_dump_i;
    end else if (i_win) begin
      mem_addr_o  = i_addr_i;
      mem_rd_o    = 1'b1;
    end
  end

  // Saturating count of consecutive cycles fetch asked and lost.
  always_comb begin
    starve_d = '0;
    if (i_rd_i & ~i_acc)
      starve_d = (starve_q == MAX_CNT) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      vld_q    <= '0;
      src_q    <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q[0] <= rd_acc;
      src_q[0] <= rd_acc & i_acc;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        src_q[k] <= src_q[k-1];
      end
    end
  end

  // Return steering from the last tag stage.
  always_comb begin
    d_rvalid_o = 1'b0;
    i_rvalid_o = 1'b0;
    d_rdata_o  = '0;
    i_rdata_o  = '0;
    if (~rst_i & vld_q[RD_LAT-1]) begin
      if (src_q[RD_LAT-1]) begin
        i_rvalid_o = 1'b1;
        i_rdata_o  = mem_rdata_i;
      end else begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (RD_LAT=2, MAX_WAIT=3). Inputs change on
// the falling edge; combinational outputs are checked 1ns later, well
// before the next rising edge commits state.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_rd, d_wr, d_dump, i_rd, mem_stall;
  logic [15:0] d_addr, d_wdata, i_addr, mem_rdata;
  logic        d_stall, d_acc, d_rvalid, i_stall, i_acc, i_rvalid;
  logic        mem_rd, mem_wr, mem_dump, err;
  logic [15:0] d_rdata, i_rdata, mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(2), .MAX_WAIT(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .d_rd_i(d_rd), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_dump_i(d_dump), .d_stall_o(d_stall), .d_acc_o(d_acc),
    .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .i_rd_i(i_rd), .i_addr_i(i_addr), .i_stall_o(i_stall), .i_acc_o(i_acc),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rd_o(mem_rd),
    .mem_wr_o(mem_wr), .mem_dump_o(mem_dump), .mem_stall_i(mem_stall),
    .mem_rdata_i(mem_rdata), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then let inputs settle.
  task automatic nxt();
    @(negedge clk);
  endtask

  // Packed strobe view: {mem_rd, mem_wr, mem_dump, d_acc, i_acc, d_rvalid, i_rvalid, err}
  function automatic logic [7:0] strobes();
    return {mem_rd, mem_wr, mem_dump, d_acc, i_acc, d_rvalid, i_rvalid, err};
  endfunction

  initial begin
    rst = 1'b1; d_rd = 1'b0; d_wr = 1'b0; d_dump = 1'b0; i_rd = 1'b0;
    mem_stall = 1'b0; d_addr = '0; d_wdata = '0; i_addr = '0; mem_rdata = '0;

    // Reset held 3 cycles with every request high: nothing may leak out.
    nxt();
    d_rd = 1'b1; d_wr = 1'b1; d_dump = 1'b1; i_rd = 1'b1;
    d_addr = 16'h0033; i_addr = 16'h0044; mem_rdata = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_strobes", {24'd0, strobes()}, 32'h0);
      chk("rst_data", {mem_addr, d_rdata | i_rdata | mem_wdata}, 32'h0);
      nxt();
    end

    // First cycle out of reset: D read 0x0010.
    rst = 1'b0; d_wr = 1'b0; d_dump = 1'b0; i_rd = 1'b0;
    d_addr = 16'h0010; mem_rdata = 16'h0000;
    #1;
    chk("post_rst_acc", {d_acc, mem_rd, mem_wr}, 3'b110);
    chk("post_rst_addr", mem_addr, 16'h0010);
    // Single read 0x0020 back-to-back.
    nxt(); d_addr = 16'h0020; #1;
    chk("rd2_acc", {d_acc, d_rvalid, mem_addr}, {2'b10, 16'h0020});
    nxt(); d_rd = 1'b0; mem_rdata = 16'h1111; #1;
    chk("rd1_ret", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 16'h1111});
    nxt(); mem_rdata = 16'hBEEF; #1;
    chk("rd2_ret", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 16'hBEEF});
    nxt(); mem_rdata = 16'h0000; #1;
    chk("rd_idle", {d_rvalid, i_rvalid}, 2'b00);

    // Contention: D wins 3 cycles, I wins the 4th.
    nxt(); d_rd = 1'b1; i_rd = 1'b1; d_addr = 16'h0030; i_addr = 16'h0040; #1;
    chk("cont1", {d_acc, i_acc, i_stall, mem_addr}, {3'b101, 16'h0030});
    nxt(); #1;
    chk("cont2", {d_acc, i_acc, i_stall, mem_addr}, {3'b101, 16'h0030});
    nxt(); mem_rdata = 16'hD001; #1;
    chk("cont3", {d_acc, i_acc, i_stall, mem_addr}, {3'b101, 16'h0030});
    chk("cont3_ret", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 16'hD001});
    nxt(); mem_rdata = 16'hD002; #1;
    chk("cont4", {d_acc, i_acc, d_stall, i_stall, mem_addr}, {4'b0110, 16'h0040});
    chk("cont4_ret", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 16'hD002});
    nxt(); d_rd = 1'b0; i_rd = 1'b0; mem_rdata = 16'hD003; #1;
    chk("cont5_ret", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 16'hD003});
    nxt(); mem_rdata = 16'hCAFE; #1;
    chk("cont6_ret", {d_rvalid, i_rvalid, i_rdata, d_rdata}, {2'b01, 16'hCAFE, 16'h0000});

    // Memory stall on a D write for 2 cycles.
    nxt(); mem_rdata = 16'h0000;
    d_wr = 1'b1; d_addr = 16'h0008; d_wdata = 16'h5A5A; mem_stall = 1'b1; #1;
    chk("stall1", {d_stall, d_acc, d_rvalid, i_rvalid}, 4'b1000);
    nxt(); #1;
    chk("stall2", {d_stall, d_acc, d_rvalid, i_rvalid}, 4'b1000);
    nxt(); mem_stall = 1'b0; #1;
    chk("stall_acc", {d_stall, d_acc, mem_wr, mem_rd, mem_wdata}, {4'b0110, 16'h5A5A});
    nxt(); d_wr = 1'b0; #1;
    chk("wr_norv1", {d_rvalid, i_rvalid}, 2'b00);
    nxt(); #1;
    chk("wr_norv2", {d_rvalid, i_rvalid}, 2'b00);

    // Interleaved reads: I at t, D at t+1.
    nxt(); i_rd = 1'b1; i_addr = 16'h0100; #1;
    chk("il_i_acc", {i_acc, d_acc, mem_rd, mem_addr}, {3'b101, 16'h0100});
    nxt(); i_rd = 1'b0; d_rd = 1'b1; d_addr = 16'h0200; #1;
    chk("il_d_acc", {i_acc, d_acc, mem_addr}, {2'b01, 16'h0200});
    nxt(); d_rd = 1'b0; mem_rdata = 16'h0101; #1;
    chk("il_i_ret", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 16'h0101});
    nxt(); mem_rdata = 16'h0202; #1;
    chk("il_d_ret", {i_rvalid, d_rvalid, d_rdata}, {2'b01, 16'h0202});

    // Read+write together: flagged, issued as a write.
    nxt(); mem_rdata = 16'h0000;
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0050; d_wdata = 16'h1234; #1;
    chk("err_wr", {err, mem_wr, mem_rd, d_acc, mem_wdata}, {4'b1101, 16'h1234});
    // Read accepted at t, reset at t+1: nothing returns at t+2.
    nxt(); d_wr = 1'b0; d_addr = 16'h0060; #1;
    chk("pre_rst_rd", {err, d_acc, mem_rd}, 3'b011);
    nxt(); d_rd = 1'b0; rst = 1'b1; #1;
    chk("mid_rst", {24'd0, strobes()}, 32'h0);
    nxt(); rst = 1'b0; mem_rdata = 16'hDEAD; #1;
    chk("flush_norv", {d_rvalid, i_rvalid, d_rdata}, {2'b00, 16'h0000});

    // Starve counter cleared by reset: D wins again with both requesting.
    nxt(); d_rd = 1'b1; i_rd = 1'b1; d_addr = 16'h0070; i_addr = 16'h0080; #1;
    chk("starve_clr", {d_acc, i_acc, mem_addr}, {2'b10, 16'h0070});
    nxt(); d_rd = 1'b0; i_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
